adc_multi_sum: RTL and testbench
================================

ADC_MULTI_SUM -- requirements
Module: adc_multi_sum

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent ADC channels, range 1..16.
REQ-002 Parameter DATA_WIDTH, default 16: per-channel sample width.
REQ-003 Parameter SUM_WIDTH, default 32: per-channel accumulator width; SUM_WIDTH >= DATA_WIDTH shall hold.
REQ-004 Parameter COUNT_WIDTH, default 16: per-channel sample-counter width.
REQ-005 Parameter SIGNED_DATA, default 0: 1 = samples are two's complement and sign-extended; 0 = unsigned and zero-extended.
REQ-006 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port data, input, CHANNELS*DATA_WIDTH: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port data_ready, input, CHANNELS: per-channel sample strobe, one sample per high cycle.
REQ-010 Port gate, input, 1: accumulation window; samples are accepted only while the window is open.
REQ-011 Port sclr, input, 1: synchronous clear.
REQ-012 Port q, output, CHANNELS*SUM_WIDTH: latched window sums, packed like data.
REQ-013 Port count, output, CHANNELS*COUNT_WIDTH: latched window sample counts.
REQ-014 Port overflow, output, CHANNELS: latched per-channel saturation flags.
REQ-015 Port result_valid, output, 1: one-cycle pulse when q/count/overflow update.
REQ-016 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-017 FSM states: IDLE, ACCUM, DUMP.
REQ-018 IDLE: go to ACCUM when gate=1. The sample strobed in that same cycle is accepted.
REQ-019 ACCUM: stay while gate=1; go to DUMP when gate=0. The gate=0 cycle accepts no samples.
REQ-020 DUMP lasts exactly one cycle:
  - copy the running sums, counts and overflow flags to q/count/overflow;
  - assert result_valid;
  - clear the running sums, counts and flags;
  - go to ACCUM if gate=1, else go to IDLE.
  Samples strobed during DUMP are dropped.
REQ-021 In IDLE or ACCUM, channel i accepts a sample when gate=1 and data_ready[i]=1. On acceptance:
  - the running sum of channel i adds the extended sample;
  - the running count of channel i increments;
  both on the next rising edge.
REQ-022 Channels accumulate independently. Any combination of data_ready bits may be high in one cycle.
REQ-023 Sum saturation:
  - unsigned mode: clamp at 2^SUM_WIDTH-1;
  - signed mode: clamp at +2^(SUM_WIDTH-1)-1 or -2^(SUM_WIDTH-1).
  The running overflow flag of that channel sets and stays set until DUMP.
REQ-024 Count saturation: once a count reaches 2^COUNT_WIDTH-1, later samples on that channel are discarded. Neither the sum nor the count changes, and the running overflow flag sets.
REQ-025 q, count and overflow hold their values between DUMP cycles. Running values are never visible on the outputs.
REQ-026 Latency: the last accepted sample of a window appears on q two edges after gate falls, coincident with result_valid.
REQ-027 sclr=1 (synchronous, priority over all other inputs except rst_n):
  - clears the running sums, counts and flags;
  - forces IDLE;
  - suppresses result_valid;
  - leaves q, count and overflow unchanged.
REQ-028 Windows with zero accepted samples still produce DUMP, with q=0, count=0 and overflow=0.

Reset
REQ-029 rst_n=0 immediately forces:
  - state IDLE;
  - all running registers to 0;
  - q, count, overflow, result_valid and busy to 0.
REQ-030 Reset asserted mid-window discards the partial window. No result_valid is issued after reset is released.

Verification
REQ-031 CHANNELS=2, unsigned. Gate high 4 cycles; ch0 strobed every cycle with 100; ch1 strobed twice with 7 -> one result_valid pulse 2 cycles after gate falls; q0=400, count0=4; q1=14, count1=2; overflow=00.
REQ-032 SIGNED_DATA=1, DATA_WIDTH=16. Samples 0xFFFF, 0xFFFE, 0x0001 on ch0 -> q0=-2 (0xFFFFFFFE), count0=3.
REQ-033 SUM_WIDTH=17, unsigned. Three samples of 0xFFFF -> q0=0x1FFFF, count0=3, overflow[0]=1. The next window with one sample of 5 -> q0=5, overflow[0]=0.
REQ-034 Gate low for 1 cycle between two windows, with data_ready high throughout -> the sample in the DUMP cycle is dropped and the second window's count excludes it; back-to-back result_valid pulses are correct.
REQ-035 Windowing boundaries:
  - sclr pulsed mid-window -> no result_valid and q unchanged; the next window starts from 0;
  - rst_n pulsed low mid-window -> all outputs 0 asynchronously.
REQ-036 COUNT_WIDTH=2. Five samples of 1 -> count0=3, q0=3, overflow[0]=1.

Source files
------------

// File: rtl/adc_multi_sum_if.sv
// adc_multi_sum_if: sample/strobe inputs and latched window results of adc_multi_sum
// master: drives data, data_ready, gate, sclr; observes q, count, overflow, result_valid, busy
// slave:  the accumulator side of the same signals
interface adc_multi_sum_if #(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SUM_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16
);
    logic [CHANNELS*DATA_WIDTH-1:0]  data;
    logic [CHANNELS-1:0]             data_ready;
    logic                            gate;
    logic                            sclr;
    logic [CHANNELS*SUM_WIDTH-1:0]   q;
    logic [CHANNELS*COUNT_WIDTH-1:0] count;
    logic [CHANNELS-1:0]             overflow;
    logic                            result_valid;
    logic                            busy;

    modport master (
        output data, data_ready, gate, sclr,
        input  q, count, overflow, result_valid, busy
    );

    modport slave (
        input  data, data_ready, gate, sclr,
        output q, count, overflow, result_valid, busy
    );
endinterface

// File: rtl/adc_multi_sum.sv
// adc_multi_sum: per-channel gated ADC sample accumulator with saturating sums and counts
// clk, rst_n (async active-low); bus.data/data_ready: per-channel samples and strobes;
// bus.gate: accumulation window; bus.sclr: sync clear; bus.q/count/overflow: latched window
// results; bus.result_valid: one-cycle pulse on update; bus.busy: state not IDLE
module adc_multi_sum #(
    parameter int CHANNELS    = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SUM_WIDTH   = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int SIGNED_DATA = 0
) (
    input logic            clk,
    input logic            rst_n,
    adc_multi_sum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;
    state_t state, state_nxt;
    logic   accept, dump, rv_r;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // sclr overrides everything: stay/return to IDLE, accept nothing, skip the dump
    always_comb begin
        state_nxt = IDLE;
        accept    = 1'b0;
        dump      = 1'b0;
        if (!bus.sclr) begin
            accept    = state != DUMP && bus.gate;
            dump      = state == DUMP;
            state_nxt = bus.gate ? ACCUM : (state == ACCUM ? DUMP : IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rv_r <= 1'b0;
        else        rv_r <= dump;

    assign bus.result_valid = rv_r;
    assign bus.busy         = state != IDLE;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DATA_WIDTH-1:0]  sample;
        logic [SUM_WIDTH:0]     ext, wide;
        logic [SUM_WIDTH-1:0]   sum_r, sat, q_r;
        logic [COUNT_WIDTH-1:0] cnt_r, cnt_q;
        logic                   ov_r, ov_q, sum_ovf, take, cnt_full, s_sx, r_sx;

        assign sample = bus.data[i*DATA_WIDTH +: DATA_WIDTH];
        assign s_sx   = SIGNED_DATA != 0 && sample[DATA_WIDTH-1];
        assign r_sx   = SIGNED_DATA != 0 && sum_r[SUM_WIDTH-1];
        // one guard bit above the sum: carry-out (unsigned) or sign disagreement (signed) flags overflow
        assign ext     = {{(SUM_WIDTH + 1 - DATA_WIDTH){s_sx}}, sample};
        assign wide    = {r_sx, sum_r} + ext;
        assign sum_ovf = SIGNED_DATA != 0 ? wide[SUM_WIDTH] ^ wide[SUM_WIDTH-1] : wide[SUM_WIDTH];
        // guard bit holds the true sign, so it selects min or max in signed mode
        assign sat      = SIGNED_DATA != 0 ? {wide[SUM_WIDTH], {(SUM_WIDTH - 1){~wide[SUM_WIDTH]}}}
                                           : {SUM_WIDTH{1'b1}};
        assign cnt_full = &cnt_r;
        assign take     = accept && bus.data_ready[i];

        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                sum_r <= '0;
                cnt_r <= '0;
                ov_r  <= 1'b0;
            end else if (bus.sclr || dump) begin
                sum_r <= '0;
                cnt_r <= '0;
                ov_r  <= 1'b0;
            end else if (take) begin
                ov_r <= ov_r | cnt_full | sum_ovf;
                // a full counter discards the sample entirely
                if (!cnt_full) begin
                    sum_r <= sum_ovf ? sat : wide[SUM_WIDTH-1:0];
                    cnt_r <= cnt_r + 1'b1;
                end
            end

        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                q_r   <= '0;
                cnt_q <= '0;
                ov_q  <= 1'b0;
            end else if (dump) begin
                q_r   <= sum_r;
                cnt_q <= cnt_r;
                ov_q  <= ov_r;
            end

        assign bus.q[i*SUM_WIDTH +: SUM_WIDTH]         = q_r;
        assign bus.count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
        assign bus.overflow[i]                         = ov_q;
    end
endmodule

// File: tb/tb_adc_multi_sum.sv
// tb_adc_multi_sum: two adc_multi_sum configurations driven in lockstep against a window-level model
module tb_adc_multi_sum;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // u: unsigned, 17-bit sums, 16-bit counts; s: signed, 32-bit sums, 2-bit counts
    adc_multi_sum_if #(.CHANNELS(2), .DATA_WIDTH(16), .SUM_WIDTH(17), .COUNT_WIDTH(16)) bus_u ();
    adc_multi_sum_if #(.CHANNELS(2), .DATA_WIDTH(16), .SUM_WIDTH(32), .COUNT_WIDTH(2))  bus_s ();

    adc_multi_sum #(.CHANNELS(2), .DATA_WIDTH(16), .SUM_WIDTH(17), .COUNT_WIDTH(16), .SIGNED_DATA(0))
        dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u.slave));
    adc_multi_sum #(.CHANNELS(2), .DATA_WIDTH(16), .SUM_WIDTH(32), .COUNT_WIDTH(2), .SIGNED_DATA(1))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

    assign bus_s.data       = bus_u.data;
    assign bus_s.data_ready = bus_u.data_ready;
    assign bus_s.gate       = bus_u.gate;
    assign bus_s.sclr       = bus_u.sclr;

    int     sw[2] = '{17, 32};
    int     cw[2] = '{16, 2};
    bit     sg[2] = '{1'b0, 1'b1};
    longint run_sum[2][2], run_cnt[2][2], exp_q[2][2], exp_cnt[2][2];
    bit     run_ov[2][2], exp_ov[2][2];
    bit     exp_rv, exp_busy, win, dump_due;
    int     n_cmp = 0, n_bad = 0, rv_seen = 0, rv_want = 0;

    function automatic logic [33:0] pq_u();
        logic [33:0] r;
        longint v;
        for (int c = 0; c < 2; c++) begin v = exp_q[0][c]; r[c*17 +: 17] = v[16:0]; end
        return r;
    endfunction
    function automatic logic [31:0] pc_u();
        logic [31:0] r;
        longint v;
        for (int c = 0; c < 2; c++) begin v = exp_cnt[0][c]; r[c*16 +: 16] = v[15:0]; end
        return r;
    endfunction
    function automatic logic [63:0] pq_s();
        logic [63:0] r;
        longint v;
        for (int c = 0; c < 2; c++) begin v = exp_q[1][c]; r[c*32 +: 32] = v[31:0]; end
        return r;
    endfunction
    function automatic logic [3:0] pc_s();
        logic [3:0] r;
        longint v;
        for (int c = 0; c < 2; c++) begin v = exp_cnt[1][c]; r[c*2 +: 2] = v[1:0]; end
        return r;
    endfunction
    function automatic logic [1:0] pov(input int d);
        return {exp_ov[d][1], exp_ov[d][0]};
    endfunction

    task automatic clr_run();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin run_sum[d][c] = 0; run_cnt[d][c] = 0; run_ov[d][c] = 0; end
    endtask

    task automatic clr_all();
        clr_run();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin exp_q[d][c] = 0; exp_cnt[d][c] = 0; exp_ov[d][c] = 0; end
        exp_rv = 0; exp_busy = 0; win = 0; dump_due = 0;
    endtask

    // one sample arriving on an open window, judged by the saturation rules
    task automatic take(input int d, input int c, input logic [15:0] x);
        longint e, mx, mn, t;
        e  = sg[d] ? longint'($signed(x)) : longint'(x);
        mx = sg[d] ? (longint'(1) << (sw[d] - 1)) - 1 : (longint'(1) << sw[d]) - 1;
        mn = sg[d] ? -(longint'(1) << (sw[d] - 1)) : 0;
        if (run_cnt[d][c] == (longint'(1) << cw[d]) - 1) run_ov[d][c] = 1;
        else begin
            run_cnt[d][c]++;
            t = run_sum[d][c] + e;
            if (t > mx) begin t = mx; run_ov[d][c] = 1; end
            else if (t < mn) begin t = mn; run_ov[d][c] = 1; end
            run_sum[d][c] = t;
        end
    endtask

    // drive one cycle of inputs, advance the window model, return at posedge+1
    task automatic cycle(input bit g, input bit [1:0] rdy, input logic [15:0] d0, input logic [15:0] d1,
                         input bit s);
        bus_u.gate = g; bus_u.data_ready = rdy; bus_u.data = {d1, d0}; bus_u.sclr = s;
        exp_rv = 0;
        if (s) begin clr_run(); win = 0; dump_due = 0; end
        else if (dump_due) begin
            exp_q = run_sum; exp_cnt = run_cnt; exp_ov = run_ov;
            exp_rv = 1; clr_run(); win = g; dump_due = 0;
        end else if (g) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < 2; c++)
                    if (rdy[c]) take(d, c, c ? d1 : d0);
            win = 1;
        end else if (win) begin dump_due = 1; win = 0; end
        exp_busy = win | dump_due;
        @(posedge clk);
        #1;
        if (bus_u.result_valid) rv_seen++;
        if (exp_rv) rv_want++;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus_u.q !== 34'd0 || bus_s.q !== 64'd0) begin n_bad++;
            $display("FAIL reset_q: got %h/%h want 0", bus_u.q, bus_s.q); end
        n_cmp++; if (bus_u.count !== 32'd0 || bus_s.count !== 4'd0) begin n_bad++;
            $display("FAIL reset_count: got %h/%h want 0", bus_u.count, bus_s.count); end
        n_cmp++; if ({bus_u.overflow, bus_s.overflow, bus_u.result_valid, bus_s.result_valid,
                      bus_u.busy, bus_s.busy} !== 8'd0) begin n_bad++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b want 0", bus_u.overflow, bus_s.overflow,
                     bus_u.result_valid, bus_s.result_valid, bus_u.busy, bus_s.busy); end
    endtask

    task automatic test_basic();
        cycle(1, 2'b11, 16'd100, 16'd7, 0);
        cycle(1, 2'b01, 16'd100, 16'd0, 0);
        cycle(1, 2'b11, 16'd100, 16'd7, 0);
        cycle(1, 2'b01, 16'd100, 16'd0, 0);
        n_cmp++; if (bus_u.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", bus_u.busy); end
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_u.result_valid !== 1'b0 || bus_u.q !== 34'd0) begin n_bad++;
            $display("FAIL basic_early: rv %b q %h want rv 0 q 0", bus_u.result_valid, bus_u.q); end
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_u.result_valid !== 1'b1 || bus_s.result_valid !== 1'b1) begin n_bad++;
            $display("FAIL basic_rv: got %b/%b want 1/1", bus_u.result_valid, bus_s.result_valid); end
        n_cmp++; if (bus_u.q !== {17'd14, 17'd400}) begin n_bad++;
            $display("FAIL basic_q: got %h want %h", bus_u.q, {17'd14, 17'd400}); end
        n_cmp++; if (bus_u.count !== {16'd2, 16'd4} || bus_u.overflow !== 2'b00) begin n_bad++;
            $display("FAIL basic_count: got %h ov %b want 00020004 ov 00", bus_u.count, bus_u.overflow); end
        n_cmp++; if (bus_s.q !== pq_s() || bus_s.count !== pc_s() || bus_s.overflow !== pov(1)) begin n_bad++;
            $display("FAIL basic_s: got %h %h %b want %h %h %b", bus_s.q, bus_s.count, bus_s.overflow,
                     pq_s(), pc_s(), pov(1)); end
        cycle(0, 2'b11, 16'd3, 16'd3, 0);
        n_cmp++; if (bus_u.result_valid !== 1'b0 || bus_u.busy !== 1'b0 || bus_u.q !== {17'd14, 17'd400}) begin
            n_bad++; $display("FAIL basic_hold: rv %b busy %b q %h want 0 0 %h", bus_u.result_valid,
                              bus_u.busy, bus_u.q, {17'd14, 17'd400}); end
    endtask

    task automatic test_signed();
        cycle(1, 2'b01, 16'hFFFF, 16'd0, 0);
        cycle(1, 2'b01, 16'hFFFE, 16'd0, 0);
        cycle(1, 2'b01, 16'h0001, 16'd0, 0);
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_s.q[31:0] !== 32'hFFFFFFFE || bus_s.count[1:0] !== 2'd3 || bus_s.overflow[0] !== 1'b0) begin
            n_bad++; $display("FAIL signed_q0: got %h cnt %0d ov %b want fffffffe cnt 3 ov 0",
                              bus_s.q[31:0], bus_s.count[1:0], bus_s.overflow[0]); end
        n_cmp++; if (bus_u.q !== pq_u() || bus_u.count !== pc_u()) begin n_bad++;
            $display("FAIL signed_u: got %h %h want %h %h", bus_u.q, bus_u.count, pq_u(), pc_u()); end
    endtask

    task automatic test_saturate();
        repeat (3) cycle(1, 2'b01, 16'hFFFF, 16'd0, 0);
        repeat (2) cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_u.q[16:0] !== 17'h1FFFF || bus_u.count[15:0] !== 16'd3 || bus_u.overflow[0] !== 1'b1) begin
            n_bad++; $display("FAIL sat_q0: got %h cnt %0d ov %b want 1ffff cnt 3 ov 1",
                              bus_u.q[16:0], bus_u.count[15:0], bus_u.overflow[0]); end
        cycle(1, 2'b01, 16'd5, 16'd0, 0);
        repeat (2) cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_u.q[16:0] !== 17'd5 || bus_u.overflow[0] !== 1'b0) begin n_bad++;
            $display("FAIL sat_next: got %h ov %b want 5 ov 0", bus_u.q[16:0], bus_u.overflow[0]); end
    endtask

    task automatic test_count_sat();
        repeat (5) cycle(1, 2'b01, 16'd1, 16'd0, 0);
        repeat (2) cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_s.count[1:0] !== 2'd3 || bus_s.q[31:0] !== 32'd3 || bus_s.overflow[0] !== 1'b1) begin
            n_bad++; $display("FAIL cnt_sat: got cnt %0d q %h ov %b want 3 3 1",
                              bus_s.count[1:0], bus_s.q[31:0], bus_s.overflow[0]); end
        n_cmp++; if (bus_u.count[15:0] !== 16'd5 || bus_u.q[16:0] !== 17'd5) begin n_bad++;
            $display("FAIL cnt_wide: got cnt %0d q %h want 5 5", bus_u.count[15:0], bus_u.q[16:0]); end
    endtask

    task automatic test_back_to_back();
        bit g[10] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            cycle(g[k], 2'b01, 16'd1, 16'd0, 0);
            n_cmp++; if (bus_u.result_valid !== exp_rv || bus_u.busy !== exp_busy) begin n_bad++;
                $display("FAIL b2b_cyc%0d: rv %b busy %b want %b %b", k, bus_u.result_valid, bus_u.busy,
                         exp_rv, exp_busy); end
            if (k == 4) begin
                n_cmp++; if (bus_u.count[15:0] !== 16'd3) begin n_bad++;
                    $display("FAIL b2b_first: got %0d want 3", bus_u.count[15:0]); end
            end
        end
        n_cmp++; if (bus_u.count[15:0] !== 16'd2 || bus_u.q[16:0] !== 17'd2) begin n_bad++;
            $display("FAIL b2b_second: got cnt %0d q %0d want 2 2", bus_u.count[15:0], bus_u.q[16:0]); end
    endtask

    task automatic test_zero_window();
        repeat (2) cycle(1, 2'b00, 16'd9, 16'd9, 0);
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_u.result_valid !== 1'b1 || bus_u.q !== 34'd0 || bus_u.count !== 32'd0 ||
                     bus_s.overflow !== 2'b00) begin n_bad++;
            $display("FAIL zero_win: rv %b q %h cnt %h ov %b want 1 0 0 00", bus_u.result_valid, bus_u.q,
                     bus_u.count, bus_s.overflow); end
    endtask

    task automatic test_sclr();
        int rv0;
        repeat (2) cycle(1, 2'b11, 16'd50, 16'd60, 0);
        rv0 = rv_seen;
        cycle(1, 2'b11, 16'd50, 16'd60, 1);
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (rv_seen != rv0 || bus_u.busy !== 1'b0) begin n_bad++;
            $display("FAIL sclr_rv: pulses %0d busy %b want 0 0", rv_seen - rv0, bus_u.busy); end
        n_cmp++; if (bus_u.q !== 34'd0 || bus_u.count !== 32'd0) begin n_bad++;
            $display("FAIL sclr_hold: got %h %h want 0 0", bus_u.q, bus_u.count); end
        repeat (2) cycle(1, 2'b01, 16'd9, 16'd0, 0);
        repeat (2) cycle(0, 2'b00, 16'd0, 16'd0, 0);
        n_cmp++; if (bus_u.q !== {17'd0, 17'd18} || bus_u.count !== {16'd0, 16'd2}) begin n_bad++;
            $display("FAIL sclr_next: got %h %h want 18 2", bus_u.q, bus_u.count); end
    endtask

    task automatic test_reset_mid();
        int rv0;
        repeat (3) cycle(1, 2'b11, 16'd4, 16'd5, 0);
        rst_n = 1'b0;
        #2;
        test_reset();
        clr_all();
        bus_u.gate = 0; bus_u.data_ready = 0; bus_u.sclr = 0;
        #2 rst_n = 1'b1;
        rv0 = rv_seen;
        repeat (3) cycle(0, 2'b11, 16'd4, 16'd5, 0);
        n_cmp++; if (rv_seen != rv0 || bus_u.busy !== 1'b0 || bus_u.q !== 34'd0) begin n_bad++;
            $display("FAIL rst_after: pulses %0d busy %b q %h want 0 0 0", rv_seen - rv0, bus_u.busy, bus_u.q); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [15:0] d0, d1;
            d0 = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
            d1 = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
            cycle($urandom_range(0, 4) != 0, 2'($urandom), d0, d1, $urandom_range(0, 39) == 0);
            n_cmp++; if (bus_u.q !== pq_u() || bus_u.count !== pc_u() || bus_u.overflow !== pov(0)) begin n_bad++;
                $display("FAIL rand_u%0d: got %h %h %b want %h %h %b", k, bus_u.q, bus_u.count, bus_u.overflow,
                         pq_u(), pc_u(), pov(0)); end
            n_cmp++; if (bus_s.q !== pq_s() || bus_s.count !== pc_s() || bus_s.overflow !== pov(1)) begin n_bad++;
                $display("FAIL rand_s%0d: got %h %h %b want %h %h %b", k, bus_s.q, bus_s.count, bus_s.overflow,
                         pq_s(), pc_s(), pov(1)); end
            n_cmp++; if (bus_u.result_valid !== exp_rv || bus_s.result_valid !== exp_rv ||
                         bus_u.busy !== exp_busy || bus_s.busy !== exp_busy) begin n_bad++;
                $display("FAIL rand_ctl%0d: rv %b%b busy %b%b want %b %b", k, bus_u.result_valid,
                         bus_s.result_valid, bus_u.busy, bus_s.busy, exp_rv, exp_busy); end
        end
        n_cmp++; if (rv_seen != rv_want) begin n_bad++;
            $display("FAIL rv_total: got %0d want %0d", rv_seen, rv_want); end
    endtask

    initial begin
        bus_u.gate = 0; bus_u.data_ready = 0; bus_u.data = 0; bus_u.sclr = 0;
        clr_all();
        #1 rst_n = 1'b0;
        #2 test_reset();
        @(posedge clk);
        #1 test_reset();
        rst_n = 1'b1;
        test_basic();
        test_signed();
        test_saturate();
        test_count_sat();
        test_back_to_back();
        test_zero_window();
        test_sclr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
